// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I sequencing FSM with retired-instruction counter
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       Opcode,
    input  logic [2:0]       Func_3,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PC_Write,
    output logic             Adr_Src,
    output logic             Mem_Write,
    output logic             IR_Write,
    output logic [1:0]       Result_src,
    output logic [1:0]       Alu_Src_A,
    output logic [1:0]       Alu_Src_B,
    output logic [1:0]       Alu_op,
    output logic [1:0]       Imm_Src,
    output logic             Reg_Write,
    output logic             illegal_op,
    output logic             instr_retired,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_JAL,
        S_ALUWB,
        S_BRANCH
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;
    logic [1:0]       w_imm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (instr_retired) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    assign instret = r_instret;

    always_comb begin
        w_imm = 2'b00;
        case (Opcode)
            OP_STORE:  w_imm = 2'b01;
            OP_BRANCH: w_imm = 2'b10;
            OP_JAL:    w_imm = 2'b11;
            default:   w_imm = 2'b00;
        endcase
    end

    always_comb begin
        w_next        = r_state;
        PC_Write      = 1'b0;
        Adr_Src       = 1'b0;
        Mem_Write     = 1'b0;
        IR_Write      = 1'b0;
        Result_src    = 2'b00;
        Alu_Src_A     = 2'b00;
        Alu_Src_B     = 2'b00;
        Alu_op        = 2'b00;
        Imm_Src       = w_imm;
        Reg_Write     = 1'b0;
        illegal_op    = 1'b0;
        instr_retired = 1'b0;

        case (r_state)
            S_FETCH: begin
                Alu_Src_B  = 2'b10;
                Result_src = 2'b10;
                IR_Write   = mem_ready;
                PC_Write   = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                Alu_Src_A = 2'b01;
                Alu_Src_B = 2'b01;
                case (Opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECUTER;
                    OP_ITYPE:          w_next = S_EXECUTEI;
                    OP_JAL:            w_next = S_JAL;
                    OP_BRANCH:         w_next = S_BRANCH;
                    default: begin
                        w_next     = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                Alu_Src_A = 2'b10;
                Alu_Src_B = 2'b01;
                w_next    = (Opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                Adr_Src = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                Result_src    = 2'b01;
                Reg_Write     = 1'b1;
                instr_retired = 1'b1;
                w_next        = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe held through the wait so slow memories see a stable request
                Adr_Src   = 1'b1;
                Mem_Write = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    w_next        = S_FETCH;
                end
            end
            S_EXECUTER: begin
                Alu_Src_A = 2'b10;
                Alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_EXECUTEI: begin
                Alu_Src_A = 2'b10;
                Alu_Src_B = 2'b01;
                Alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_JAL: begin
                Alu_Src_A = 2'b01;
                Alu_Src_B = 2'b10;
                PC_Write  = 1'b1;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                Reg_Write     = 1'b1;
                instr_retired = 1'b1;
                w_next        = S_FETCH;
            end
            S_BRANCH: begin
                Alu_Src_A     = 2'b10;
                Alu_op        = 2'b01;
                instr_retired = 1'b1;
                case (Func_3)
                    3'b000:  PC_Write = Zero;
                    3'b001:  PC_Write = ~Zero;
                    default: PC_Write = 1'b0;
                endcase
                w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset must silence every strobe and select immediately, not at the next edge
        if (!rst_n) begin
            PC_Write      = 1'b0;
            Adr_Src       = 1'b0;
            Mem_Write     = 1'b0;
            IR_Write      = 1'b0;
            Result_src    = 2'b00;
            Alu_Src_A     = 2'b00;
            Alu_Src_B     = 2'b00;
            Alu_op        = 2'b00;
            Imm_Src       = 2'b00;
            Reg_Write     = 1'b0;
            illegal_op    = 1'b0;
            instr_retired = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - vector table, random instruction stream and reset corner cases
module tb_multicycle_controller;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    Opcode;
    logic [2:0]    Func_3;
    logic          Zero;
    logic          mem_ready;
    logic          PC_Write, Adr_Src, Mem_Write, IR_Write;
    logic [1:0]    Result_src, Alu_Src_A, Alu_Src_B, Alu_op, Imm_Src;
    logic          Reg_Write, illegal_op, instr_retired;
    logic [CW-1:0] instret;

    multicycle_controller #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Func_3(Func_3), .Zero(Zero),
        .mem_ready(mem_ready), .PC_Write(PC_Write), .Adr_Src(Adr_Src),
        .Mem_Write(Mem_Write), .IR_Write(IR_Write), .Result_src(Result_src),
        .Alu_Src_A(Alu_Src_A), .Alu_Src_B(Alu_Src_B), .Alu_op(Alu_op),
        .Imm_Src(Imm_Src), .Reg_Write(Reg_Write), .illegal_op(illegal_op),
        .instr_retired(instr_retired), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic [16:0] out;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
        int         wf;
        int         wm;
        int         exp_cycles;
        int         exp_ret;
    } vec_t;

    cyc_t          exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [CW-1:0] model_cnt = '0;

    function automatic logic [16:0] v(logic pcw, logic adr, logic mw, logic irw,
                                      logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                                      logic [1:0] op, logic rw, logic ill, logic ret,
                                      logic [1:0] imm);
        return {pcw, adr, mw, irw, rs, a, b, op, imm, rw, ill, ret};
    endfunction

    function automatic logic [16:0] dut_out();
        return {PC_Write, Adr_Src, Mem_Write, IR_Write, Result_src, Alu_Src_A,
                Alu_Src_B, Alu_op, Imm_Src, Reg_Write, illegal_op, instr_retired};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] imm_of(logic [6:0] op);
        case (op)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    // Expected per-cycle output sequence, written from the instruction's phase list
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic z,
                         input int wf, input int wm, output logic ret);
        logic [1:0] im;
        logic       pcw;
        bit         legal;
        im    = imm_of(op);
        legal = (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
                (op == 7'b0010011) || (op == 7'b1101111) || (op == 7'b1100011);
        ret   = legal;
        for (int i = 0; i < wf; i++) exp_q.push_back('{1'b0, v(0,0,0,0,2,0,2,0,0,0,0,im)});
        exp_q.push_back('{1'b1, v(1,0,0,1,2,0,2,0,0,0,0,im)});
        exp_q.push_back('{rnd(), v(0,0,0,0,0,1,1,0,0,!legal,0,im)});
        case (op)
            7'b0000011: begin
                exp_q.push_back('{rnd(), v(0,0,0,0,0,2,1,0,0,0,0,im)});
                for (int i = 0; i < wm; i++) exp_q.push_back('{1'b0, v(0,1,0,0,0,0,0,0,0,0,0,im)});
                exp_q.push_back('{1'b1, v(0,1,0,0,0,0,0,0,0,0,0,im)});
                exp_q.push_back('{rnd(), v(0,0,0,0,1,0,0,0,1,0,1,im)});
            end
            7'b0100011: begin
                exp_q.push_back('{rnd(), v(0,0,0,0,0,2,1,0,0,0,0,im)});
                for (int i = 0; i < wm; i++) exp_q.push_back('{1'b0, v(0,1,1,0,0,0,0,0,0,0,0,im)});
                exp_q.push_back('{1'b1, v(0,1,1,0,0,0,0,0,0,0,1,im)});
            end
            7'b0110011, 7'b0010011, 7'b1101111: begin
                if (op == 7'b0110011)      exp_q.push_back('{rnd(), v(0,0,0,0,0,2,0,2,0,0,0,im)});
                else if (op == 7'b0010011) exp_q.push_back('{rnd(), v(0,0,0,0,0,2,1,2,0,0,0,im)});
                else                       exp_q.push_back('{rnd(), v(1,0,0,0,0,1,2,0,0,0,0,im)});
                exp_q.push_back('{rnd(), v(0,0,0,0,0,0,0,0,1,0,1,im)});
            end
            7'b1100011: begin
                pcw = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0;
                exp_q.push_back('{rnd(), v(pcw,0,0,0,0,2,0,1,0,0,1,im)});
            end
            default: ;
        endcase
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int wf, input int wm, output int lat);
        logic ret;
        exp_q.delete();
        build(op, f3, z, wf, wm, ret);
        lat = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            Opcode    = op;
            Func_3    = f3;
            Zero      = (op == 7'b1100011) ? z : rnd();
            mem_ready = exp_q[i].mr;
            #1;
            check($sformatf("op%b f3=%0d cyc%0d", op, f3, i), 32'(dut_out()), 32'(exp_q[i].out));
            if (lat == 0 && (instr_retired || illegal_op)) lat = i + 1;
        end
        if (ret) model_cnt = model_cnt + 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check($sformatf("instret after op%b", op), 32'(instret), 32'(model_cnt));
    endtask

    vec_t tbl[13];
    logic [6:0] legal_ops[6];

    initial begin
        int lat;
        tbl[0]  = '{7'b0110011, 3'd0, 1'b0, 0, 0, 4, 1};
        tbl[1]  = '{7'b0010011, 3'd2, 1'b1, 0, 0, 4, 1};
        tbl[2]  = '{7'b0000011, 3'd2, 1'b0, 0, 3, 8, 1};
        tbl[3]  = '{7'b0000011, 3'd2, 1'b0, 0, 0, 5, 1};
        tbl[4]  = '{7'b0100011, 3'd2, 1'b0, 0, 2, 6, 1};
        tbl[5]  = '{7'b0100011, 3'd2, 1'b0, 0, 0, 4, 1};
        tbl[6]  = '{7'b1100011, 3'd0, 1'b1, 0, 0, 3, 1};
        tbl[7]  = '{7'b1100011, 3'd1, 1'b1, 0, 0, 3, 1};
        tbl[8]  = '{7'b1100011, 3'd1, 1'b0, 0, 0, 3, 1};
        tbl[9]  = '{7'b1100011, 3'd4, 1'b1, 0, 0, 3, 1};
        tbl[10] = '{7'b1101111, 3'd0, 1'b0, 0, 0, 4, 1};
        tbl[11] = '{7'b1110011, 3'd0, 1'b0, 0, 0, 2, 0};
        tbl[12] = '{7'b0110011, 3'd0, 1'b0, 2, 0, 6, 1};
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};

        rst_n = 1'b0; Opcode = 7'b0110011; Func_3 = 3'd0; Zero = 1'b0; mem_ready = 1'b1;
        #3;
        check("reset outputs", 32'(dut_out()), 32'd0);
        check("reset instret", 32'(instret), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;

        foreach (tbl[k]) begin
            run_instr(tbl[k].op, tbl[k].f3, tbl[k].z, tbl[k].wf, tbl[k].wm, lat);
            check($sformatf("latency vec%0d", k), 32'(lat), 32'(tbl[k].exp_cycles));
        end

        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 5)];
            run_instr(op, 3'($urandom), rnd(), $urandom_range(0, 2), $urandom_range(0, 3), lat);
        end

        // Reset while a store waits in MEMWRITE
        Opcode = 7'b0100011; Func_3 = 3'd2;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("memwrite strobe before reset", 32'(Mem_Write), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("strobes forced by reset", 32'(dut_out()), 32'd0);
        check("instret cleared by reset", 32'(instret), 32'd0);
        model_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("fetch after reset", 32'(dut_out()), 32'(v(0,0,0,0,2,0,2,0,0,0,0,2'b01)));
        run_instr(7'b0110011, 3'd0, 1'b0, 0, 0, lat);
        check("latency add after reset", 32'(lat), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control unit for the multi-cycle RV32I core. Walks each instruction through Fetch, Decode, Execute, Memory and Writeback states. Drives the shared-memory address mux, the instruction-register and PC enables, the ALU operand selects and the register-file write strobe. Waits on a memory-ready handshake, so one ALU and one unified memory are shared across cycles instead of being duplicated per stage.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- Opcode  in  7  instr[6:0] from instruction register
- Func_3  in  3  instr[14:12] from instruction register
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- PC_Write  out  1  PC register enable
- Adr_Src  out  1  memory address select: 0 = PC, 1 = ALU result register
- Mem_Write  out  1  memory write strobe
- IR_Write  out  1  instruction register and old-PC register enable
- Result_src  out  2  result mux: 00 ALUOut, 01 memory data, 10 ALU result
- Alu_Src_A  out  2  ALU operand A: 00 PC, 01 old PC, 10 rs1
- Alu_Src_B  out  2  ALU operand B: 00 rs2, 01 immediate, 10 constant 4
- Alu_op  out  2  to ALU decoder: 00 add, 01 subtract/compare, 10 by funct
- Imm_Src  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- Reg_Write  out  1  register-file write enable
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- instr_retired  out  1  one-cycle pulse when an instruction completes
- instret  out  CNT_W  count of retired instructions, wraps modulo 2^CNT_W

## Operation
- The state register is the only sequential control. All outputs except `instret` are combinational from the state plus Opcode, Func_3, Zero and mem_ready.
- Unlisted outputs in each state are 0.
- State list, with outputs and next state:
  - FETCH: Adr_Src=0, Alu_Src_A=00, Alu_Src_B=10, Alu_op=00, Result_src=10. IR_Write and PC_Write equal mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when it is 1.
  - DECODE: Alu_Src_A=01, Alu_Src_B=01, Alu_op=00 (branch target). Next state by Opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1101111 → JAL
    - 1100011 → BRANCH
    - any other opcode → FETCH, with illegal_op=1 for this cycle
  - MEMADR: Alu_Src_A=10, Alu_Src_B=01, Alu_op=00. Goes to MEMREAD if Opcode=0000011, otherwise MEMWRITE.
  - MEMREAD: Adr_Src=1, Result_src=00. Holds until mem_ready, then MEMWB.
  - MEMWB: Result_src=01, Reg_Write=1, instr_retired=1. Goes to FETCH.
  - MEMWRITE: Adr_Src=1, Result_src=00, Mem_Write=1. Holds until mem_ready. When mem_ready=1: instr_retired=1 and next state is FETCH.
  - EXECUTER: Alu_Src_A=10, Alu_Src_B=00, Alu_op=10. Goes to ALUWB.
  - EXECUTEI: Alu_Src_A=10, Alu_Src_B=01, Alu_op=10. Goes to ALUWB.
  - JAL: Alu_Src_A=01, Alu_Src_B=10, Alu_op=00, Result_src=00, PC_Write=1. Goes to ALUWB.
  - ALUWB: Result_src=00, Reg_Write=1, instr_retired=1. Goes to FETCH.
  - BRANCH: Alu_Src_A=10, Alu_Src_B=00, Alu_op=01, Result_src=00, instr_retired=1. PC_Write=Zero when Func_3=000 (beq). PC_Write=~Zero when Func_3=001 (bne). PC_Write=0 for any other Func_3. Goes to FETCH.
- Imm_Src is decoded from Opcode in every state:
  - load and OP-IMM → 00
  - store → 01
  - branch → 10
  - jal → 11
  - any other opcode → 00
- `instret` increments by 1 on every clock edge where instr_retired=1.

## Timing
- Reset (rst_n=0, asynchronous):
  - state goes to FETCH and instret goes to 0 immediately, without a clock edge.
  - While rst_n=0, PC_Write, IR_Write, Mem_Write, Reg_Write, illegal_op and instr_retired are forced to 0. All selects read 0.
- Reset released: first active edge sees FETCH.
- Reset asserted in mid-instruction: the instruction is abandoned and no write strobe is asserted afterwards.
- Latency with mem_ready held at 1, FETCH to the FETCH of the next instruction:
  - R-type, I-type and jal: 4 cycles
  - branch: 3 cycles
  - store: 4 cycles
  - load: 5 cycles
  - illegal opcode: 2 cycles
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- During such a wait, Mem_Write stays high (MEMWRITE) and the address selects stay stable.
- instret wraps from 2^CNT_W−1 to 0 with no flag.
- Opcode and Func_3 are sampled only in DECODE and later states. Their value during FETCH is ignored except for Imm_Src.

## Test plan
- Reset check: assert rst_n=0 in MEMWRITE while mem_ready=0. Required: Mem_Write drops at once, state is FETCH, instret=0.
- add (0110011), mem_ready=1: required states FETCH, DECODE, EXECUTER, ALUWB. Reg_Write=1 only in cycle 4, instret becomes 1.
- lw (0000011), mem_ready=0 for 3 cycles in MEMREAD: required 8 total cycles, and Result_src=01 with Reg_Write=1 in MEMWB.
- Branch cases (1100011):
  - Func_3=000, Zero=1: PC_Write=1 in BRANCH.
  - Func_3=001, Zero=1: PC_Write=0.
  - Func_3=001, Zero=0: PC_Write=1.
- jal (1101111): PC_Write=1 in the JAL cycle, then Reg_Write=1 with Result_src=00 in ALUWB.
- Opcode 1110011: illegal_op pulses once in DECODE and the controller returns to FETCH. No write strobes and no instret increment.
